// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: mode encodings and width helper shared by the channel selector
package mux_arb_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after ptr
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx,
    output logic            any
);
    int j;
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = SELW'(j);
            end
        end
    end
endmodule

// File: rtl/mux_arb_reg.sv
// mux_arb_reg: N-channel fixed/round-robin selector with valid/ready handshake
// and a single registered output stage that refills on the same edge it drains.
module mux_arb_reg
    import mux_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 5,
    parameter int SELW = clog2(N)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SELW-1:0] control,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_chan,
    output logic            out_valid,
    input  logic            out_ready
);
    logic [SELW-1:0] rr_ptr, rr_idx, ld_chan;
    logic [N-1:0]    rr_grant, fx_grant;
    logic [W-1:0]    ld_data;
    logic            rr_any, can_load, xfer;

    rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
        .req      (in_valid),
        .ptr      (rr_ptr),
        .grant    (rr_grant),
        .grant_idx(rr_idx),
        .any      (rr_any)
    );

    assign can_load = !out_valid || out_ready;
    assign ld_chan  = (mode == MODE_RR) ? rr_idx : control;
    // reset_n gates the handshake so nothing is accepted while held in reset
    assign xfer     = reset_n && can_load && ((mode == MODE_RR) ? rr_any : |fx_grant);

    always_comb begin
        fx_grant = '0;
        for (int i = 0; i < N; i++)
            fx_grant[i] = in_valid[i] && (int'(control) == i);
        in_ready = xfer ? ((mode == MODE_RR) ? rr_grant : fx_grant) : '0;
        ld_data = '0;
        for (int i = 0; i < N; i++)
            if (in_ready[i]) ld_data = in_data[i*W +: W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= SELW'(N - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= ld_data;
            out_chan  <= ld_chan;
            if (mode == MODE_RR) rr_ptr <= ld_chan;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_arb_reg.sv
// tb_mux_arb_reg: directed and random stimulus checked against a behavioural model
module tb_mux_arb_reg;
    localparam int N = 4;
    localparam int W = 5;
    localparam int SELW = 2;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic [N*W-1:0]  in_data = '0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_ready;
    logic            mode = 1'b0;
    logic [SELW-1:0] control = '0;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_chan;
    logic            out_valid;
    logic            out_ready = 1'b1;

    int vectors = 0;
    int fails = 0;
    int d [N];
    int m_valid, m_data, m_chan, m_ptr;

    mux_arb_reg #(.N(N), .W(W)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .control(control), .out_data(out_data),
        .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // which channel the rules say should win this cycle, or -1
    function automatic int model_grant();
        if (!mode) return (int'(control) < N && in_valid[control]) ? int'(control) : -1;
        for (int k = 1; k <= N; k++)
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic check_out();
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("out_chan", out_chan, m_chan);
    endtask

    task automatic step(input int lit_ready);
        int g, er;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(d[i]);
        #1;
        g = model_grant();
        er = ((!m_valid || out_ready) && g >= 0) ? (1 << g) : 0;
        check("in_ready", in_ready, er);
        if (lit_ready >= 0) check("in_ready_lit", in_ready, lit_ready);
        @(posedge clk);
        if (er != 0) begin
            m_valid = 1; m_data = d[g]; m_chan = g;
            if (mode) m_ptr = g;
        end else if (out_ready) m_valid = 0;
        #1;
        check_out();
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        m_valid = 0; m_data = 0; m_chan = 0; m_ptr = N - 1;
        check_out();
        check("in_ready_rst", in_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) d[i] = 0;
        mode = 1'b0; control = 2'd2; in_valid = 4'b0100; d[2] = 17; out_ready = 1'b1;
        do_reset();
        step(4'b0100);
        check("t1_valid", out_valid, 1); check("t1_data", out_data, 17); check("t1_chan", out_chan, 2);

        control = 2'd1; in_valid = 4'b1101;
        step(0);
        check("t2_valid", out_valid, 0);

        do_reset();
        mode = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < N; i++) d[i] = 10 + i;
        for (int k = 0; k < 5; k++) begin
            step(1 << (k % 4));
            check("t3_chan", out_chan, k % 4);
            check("t3_data", out_data, 10 + k % 4);
        end

        mode = 1'b0; control = 2'd0; in_valid = 4'b0001; d[0] = 9;
        step(1);
        out_ready = 1'b0; control = 2'd3; in_valid = 4'b1000; d[3] = 30;
        for (int k = 0; k < 3; k++) begin
            step(0);
            check("t4_hold", out_data, 9);
        end
        out_ready = 1'b1;
        step(4'b1000);
        check("t4_data", out_data, 30); check("t4_chan", out_chan, 3);

        do_reset();
        mode = 1'b1; in_valid = 4'b0010;
        step(4'b0010);
        in_valid = 4'b0011;
        step(4'b0001);
        check("t5_wrap", out_chan, 0);
        step(4'b0010);
        check("t5_next", out_chan, 1);

        in_valid = 4'b1111;
        step(4'b0100);
        check("t6_pre", out_valid, 1);
        do_reset();
        step(4'b0001);
        check("t6_first", out_chan, 0);

        for (int n = 0; n < 3000; n++) begin
            mode = 1'($urandom);
            control = SELW'($urandom_range(0, N - 1));
            in_valid = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) d[i] = $urandom_range(0, (1 << W) - 1);
            if ($urandom_range(0, 199) == 0) do_reset();
            step(-1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/mux_arb_reg.md
Name: mux_arb_reg

Overview:
- Parametrised N-channel selector generalising the 4:1 register-address mux.
- Adds a per-channel valid/ready handshake, a registered output stage, and two modes:
  - fixed select, driven by the control input;
  - round-robin arbitration among valid channels.
- Sits between producer stages (e.g. write-back source candidates) and a single consumer; tolerates consumer back-pressure.

Parameters:
- N, 4, number of input channels (2..16).
- W, 5, data width per channel.
- SELW, $clog2(N), width of the select and channel-index fields.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel data valid.
- in_ready  output  N  per-channel accept; a transfer occurs when in_valid[i] and in_ready[i] are both high.
- mode  input  1  0 = fixed select, 1 = round-robin.
- control  input  SELW  channel index used in fixed mode.
- out_data  output  W  registered selected data.
- out_chan  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  output register holds data.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset (async, reset_n low): out_valid=0, out_data=0, out_chan=0, rr_ptr=N-1 (channel 0 has first priority). in_ready=0 while in reset.
- Slot free: can_load = !out_valid || out_ready (single-stage pipeline, full throughput).
- Fixed mode (mode=0):
  - grant[i] = (i==control) && in_valid[i].
  - If control >= N, no grant and in_ready=0.
- Round-robin mode (mode=1):
  - Grant the first valid channel searching rr_ptr+1, rr_ptr+2, … modulo N.
  - rr_ptr updates to the granted index only on an accepted transfer.
  - rr_ptr is not altered in fixed mode.
- in_ready[i] = can_load && grant[i]:
  - at most one in_ready bit is high;
  - in_ready may depend combinationally on in_valid, and producers must not make in_valid depend on in_ready.
- Transfer cycle (any in_valid[i] && in_ready[i]): next edge loads out_data=in_data[i], out_chan=i, out_valid=1.
- Drain without refill: if out_ready=1 and no grant, next edge out_valid=0; out_data and out_chan hold their last value.
- Stall: out_valid=1 and out_ready=0 → output register holds; all in_ready=0.
- Latency: 1 cycle input-to-output.
- Throughput: one transfer per cycle when out_ready is held high.
- Mode or control change is allowed any cycle and takes effect combinationally on that cycle's grant. An already-registered output is unaffected.
- Simultaneous load and drain (out_valid=1, out_ready=1, grant present): the new word replaces the old on the same edge. No bubble.
- Reset asserted mid-transfer: output is discarded immediately and rr_ptr returns to N-1.
- Round-robin wrap-around: after granting channel N-1 the search restarts at 0.
- No valid channel: no grant, rr_ptr unchanged.

Decomposition:
- Package mux_arb_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1;
  - function clog2 for SELW derivation.
- Sub-module rr_arbiter (params N, SELW):
  - inputs req[N], ptr[SELW];
  - outputs grant[N] (one-hot or zero), grant_idx[SELW], any.
  - Purely combinational.
- The pointer register lives in mux_arb_reg.

Test Plan:
1. Reset release with N=4, W=5, mode=0, control=2, in_valid=4'b0100, in_data ch2=5'd17, out_ready=1.
   - in_ready=4'b0100.
   - Next cycle out_valid=1, out_data=17, out_chan=2.
2. Fixed mode with control=1, in_valid=4'b1101 (ch1 not valid).
   - in_ready=0, no load.
   - out_valid falls to 0 after the draining cycle.
3. Round-robin from reset, all four valid, out_ready=1 for 5 cycles.
   - out_chan sequence 0,1,2,3,0.
   - out_data matches each channel's value.
4. Back-pressure: out_valid=1, out_data=9, out_ready=0 for 3 cycles while ch3 valid with 5'd30.
   - out_data stays 9, in_ready=0.
   - Raise out_ready → next edge out_data=30, out_chan=3.
5. Round-robin with rr_ptr=1 and in_valid=4'b0011.
   - Grant ch0 (wrap past 2,3); rr_ptr becomes 0.
   - Next grant goes to ch1.
6. Assert reset_n=0 mid-stream with out_valid=1.
   - out_valid, out_data and out_chan go to 0 immediately (asynchronously).
   - After release, round-robin grants ch0 first.
